// File: rtl/ro_freq_monitor.sv
// Ring-oscillator frequency monitor: counts synchronised rising edges of NCH
// oscillator inputs over back-to-back 2^GATE_LOG2-cycle windows.
module ro_freq_monitor #(
  parameter int NCH         = 2,
  parameter int CNT_W       = 16,
  parameter int GATE_LOG2   = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   osc_in,
  input  logic [CNT_W-1:0] thr_hi,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CH_W-1:0]  ch_sel,
  output logic [CNT_W-1:0] count_out,
  output logic             sample_valid,
  output logic [NCH-1:0]   warn,
  output logic [NCH-1:0]   overflow
);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [ARM_W-1:0]     ARM_LAST   = ARM_W'(SYNC_STAGES);
  localparam logic [GATE_LOG2-1:0] TIMER_LAST = '1;
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t                 state_q, state_d;
  logic [GATE_LOG2-1:0]   timer_q, timer_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [SYNC_STAGES-1:0] sync_d [NCH];
  logic [NCH-1:0]         hist_q, hist_d;
  logic [CNT_W-1:0]       live_q [NCH];
  logic [CNT_W-1:0]       live_d [NCH];
  logic [CNT_W-1:0]       latched_q [NCH];
  logic [CNT_W-1:0]       latched_d [NCH];
  logic [NCH-1:0]         ovf_q, ovf_d;
  logic [NCH-1:0]         warn_q, warn_d;
  logic [NCH-1:0]         overflow_q, overflow_d;
  logic                   sample_valid_q, sample_valid_d;

  logic [NCH-1:0]         sync_out, edge_det, lost;
  logic [CNT_W-1:0]       sat_sum [NCH];
  logic                   terminal;

  // Synchroniser, edge detector and saturating adder per channel.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CNT_W:0] sum;
    assign sync_d[gi]   = {sync_q[gi][SYNC_STAGES-2:0], osc_in[gi]};
    assign sync_out[gi] = sync_q[gi][SYNC_STAGES-1];
    assign edge_det[gi] = sync_out[gi] & ~hist_q[gi];
    assign sum          = {1'b0, live_q[gi]} + (CNT_W+1)'(edge_det[gi]);
    assign lost[gi]     = sum[CNT_W];
    assign sat_sum[gi]  = lost[gi] ? CNT_MAX : sum[CNT_W-1:0];
  end

  assign hist_d   = sync_out;
  assign terminal = (timer_q == TIMER_LAST);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    arm_cnt_d      = arm_cnt_q;
    live_d         = live_q;
    ovf_d          = ovf_q;
    latched_d      = latched_q;
    warn_d         = warn_q;
    overflow_d     = overflow_q;
    sample_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d   = '0;
        arm_cnt_d = '0;
        ovf_d     = '0;
        for (int i = 0; i < NCH; i++) live_d[i] = '0;
        if (en) state_d = ARM;
      end
      ARM: begin
        if (!en) begin
          state_d   = IDLE;
          arm_cnt_d = '0;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d   = RUN;
          timer_d   = '0;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end
      RUN: begin
        if (!en) begin
          // Abort: the partial window is dropped, published results stay.
          state_d = IDLE;
          timer_d = '0;
          ovf_d   = '0;
          for (int i = 0; i < NCH; i++) live_d[i] = '0;
        end else begin
          timer_d        = timer_q + GATE_LOG2'(1);
          sample_valid_d = terminal;
          for (int i = 0; i < NCH; i++) begin
            if (terminal) begin
              latched_d[i]  = sat_sum[i];
              overflow_d[i] = ovf_q[i] | lost[i];
              live_d[i]     = '0;
              ovf_d[i]      = 1'b0;
              if (sat_sum[i] >= thr_hi)      warn_d[i] = 1'b1;
              else if (sat_sum[i] <= thr_lo) warn_d[i] = 1'b0;
            end else begin
              live_d[i] = sat_sum[i];
              ovf_d[i]  = ovf_q[i] | lost[i];
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      arm_cnt_q      <= '0;
      hist_q         <= '0;
      ovf_q          <= '0;
      warn_q         <= '0;
      overflow_q     <= '0;
      sample_valid_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sync_q[i]    <= '0;
        live_q[i]    <= '0;
        latched_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      arm_cnt_q      <= arm_cnt_d;
      hist_q         <= hist_d;
      ovf_q          <= ovf_d;
      warn_q         <= warn_d;
      overflow_q     <= overflow_d;
      sample_valid_q <= sample_valid_d;
      sync_q         <= sync_d;
      live_q         <= live_d;
      latched_q      <= latched_d;
    end
  end

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    count_out = latched_q[0];
    for (int i = 1; i < NCH; i++) begin
      if (int'(ch_sel) == i) count_out = latched_q[i];
    end
  end

  assign sample_valid = sample_valid_q;
  assign warn         = warn_q;
  assign overflow     = overflow_q;
endmodule
